// File: rtl/mips_dmem.sv
// mips_dmem: data-memory responder for the DM port of the mips core.
// Holds MEM_WORDS 32-bit words, answers reads one cycle after the address,
// polices the byte window and zero-fills the array after every reset.
// Optional build macro: MIPS_DMEM_BYTE_EN adds DM_BE[3:0] byte-lane enables.
module mips_dmem #(
  parameter int MEM_WORDS = 64,
  parameter int CNT_W     = 16
) (
  input  logic             DM_CLK,
  input  logic             Z_R,
  input  logic             DM_WE,
  input  logic [31:0]      DM_ADDR,
  input  logic [31:0]      DM_WR_DATA,
`ifdef MIPS_DMEM_BYTE_EN
  input  logic [3:0]       DM_BE,
`endif
  output logic [31:0]      DM_RD_DATA,
  output logic             DM_READY,
  output logic             DM_ERR,
  input  logic             ERR_CLR,
  output logic [CNT_W-1:0] RD_CNT,
  output logic [CNT_W-1:0] WR_CNT
);

  localparam int            AW        = $clog2(MEM_WORDS);
  localparam logic [31:0]   WIN_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [AW-1:0] LAST_IDX  = AW'(MEM_WORDS - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     sweep_idx_reg, sweep_idx_next;
  logic [31:0]       rd_data_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  rd_cnt_reg, wr_cnt_reg;

  logic [31:0]       mem [MEM_WORDS];

  logic              run;
  logic              in_win;
  logic              aligned;
  logic [AW-1:0]     word_idx;
  logic [3:0]        be_eff;
  logic [31:0]       merged_word;
  logic              wr_accept;
  logic              rd_accept;
  logic              err_set;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [31:0]       mem_wdata;

  // Address decode: low two bits select a byte and are ignored on reads.
  assign run      = (state_reg == ST_RUN);
  assign in_win   = (DM_ADDR < WIN_BYTES);
  assign aligned  = (DM_ADDR[1:0] == 2'b00);
  assign word_idx = DM_ADDR[AW+1:2];

`ifdef MIPS_DMEM_BYTE_EN
  assign be_eff = DM_BE;
`else
  // Without lane enables every accepted write covers the whole word.
  assign be_eff = 4'hF;
`endif

  // Merge new lanes over the stored word; this is also the write-first read value.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = be_eff[gi] ? DM_WR_DATA[8*gi +: 8]
                                                 : mem[word_idx][8*gi +: 8];
    end
  endgenerate

  // A write is legal only in RUN, inside the window, word aligned, with a lane enabled.
  assign wr_accept = run && DM_WE && in_win && aligned && (be_eff != 4'h0);
  assign rd_accept = run && !DM_WE && in_win;
  assign err_set   = DM_WE && !wr_accept;

  // FSM state register and sweep index.
  always_ff @(posedge DM_CLK or negedge Z_R) begin
    if (!Z_R) begin
      state_reg     <= ST_INIT;
      sweep_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_idx_reg <= sweep_idx_next;
    end
  end

  // Next state: sweep every word once, then stay in RUN until reset.
  always_comb begin
    state_next     = state_reg;
    sweep_idx_next = sweep_idx_reg;
    if (state_reg == ST_INIT) begin
      sweep_idx_next = sweep_idx_reg + 1'b1;
      if (sweep_idx_reg == LAST_IDX) begin
        state_next = ST_RUN;
      end
    end
  end

  // Single write port shared between the zero-fill sweep and core writes.
  always_comb begin
    mem_we    = wr_accept;
    mem_waddr = word_idx;
    mem_wdata = merged_word;
    if (state_reg == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_idx_reg;
      mem_wdata = '0;
    end
  end

  // Memory array write (no reset so it maps onto block RAM).
  always_ff @(posedge DM_CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read data: write-first on accepted writes, all-ones outside the window.
  always_ff @(posedge DM_CLK or negedge Z_R) begin
    if (!Z_R) begin
      rd_data_reg <= '0;
    end else if (wr_accept) begin
      rd_data_reg <= merged_word;
    end else if (run && !DM_WE) begin
      rd_data_reg <= in_win ? mem[word_idx] : 32'hFFFF_FFFF;
    end
  end

  // Sticky error flag; a new error wins over a simultaneous clear.
  always_ff @(posedge DM_CLK or negedge Z_R) begin
    if (!Z_R) begin
      err_reg <= 1'b0;
    end else if (err_set) begin
      err_reg <= 1'b1;
    end else if (ERR_CLR) begin
      err_reg <= 1'b0;
    end
  end

  // Saturating access counters.
  always_ff @(posedge DM_CLK or negedge Z_R) begin
    if (!Z_R) begin
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
    end else begin
      if (rd_accept && (rd_cnt_reg != '1)) begin
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
      end
      if (wr_accept && (wr_cnt_reg != '1)) begin
        wr_cnt_reg <= wr_cnt_reg + 1'b1;
      end
    end
  end

  assign DM_RD_DATA = rd_data_reg;
  assign DM_READY   = run;
  assign DM_ERR     = err_reg;
  assign RD_CNT     = rd_cnt_reg;
  assign WR_CNT     = wr_cnt_reg;

endmodule

// File: tb/tb_mips_dmem.sv
// tb_mips_dmem: randomized and directed bench for mips_dmem against a
// word-array reference model. Build with MIPS_DMEM_BYTE_EN to cover DM_BE.
module tb_mips_dmem;

  localparam int MW     = 64;
  localparam int CW     = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          z_r = 1'b1;
  logic          we = 1'b0;
  logic          clr = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [3:0]    be_drv = 4'hF;

  logic [31:0]   rd_data;
  logic          ready;
  logic          err;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] wr_cnt;

  always #5 clk = ~clk;

  mips_dmem #(.MEM_WORDS(MW), .CNT_W(CW)) dut (
    .DM_CLK     (clk),
    .Z_R        (z_r),
    .DM_WE      (we),
    .DM_ADDR    (addr),
    .DM_WR_DATA (wdata),
`ifdef MIPS_DMEM_BYTE_EN
    .DM_BE      (be_drv),
`endif
    .DM_RD_DATA (rd_data),
    .DM_READY   (ready),
    .DM_ERR     (err),
    .ERR_CLR    (clr),
    .RD_CNT     (rd_cnt),
    .WR_CNT     (wr_cnt)
  );

  // Reference model: plain array plus unbounded access tallies.
  logic [31:0] m_mem [MW];
  logic [31:0] m_rd;
  bit          m_err;
  bit          m_ready;
  int          m_rc, m_wc, m_init;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int n);
    return (n >= CNT_MAX) ? 32'(CNT_MAX) : 32'(n);
  endfunction

  task automatic model_reset();
    m_rd = '0; m_err = 0; m_ready = 0;
    m_rc = 0; m_wc = 0; m_init = 0;
    for (int i = 0; i < MW; i++) m_mem[i] = '0;
  endtask

  task automatic compare_all();
    check("rd_data", rd_data, m_rd);
    check("ready", 32'(ready), 32'(m_ready));
    check("err", 32'(err), 32'(m_err));
    check("rd_cnt", 32'(rd_cnt), sat(m_rc));
    check("wr_cnt", 32'(wr_cnt), sat(m_wc));
  endtask

  // One clock of traffic: drive, let the edge happen, advance the model, compare.
  task automatic do_cycle(input bit w, input logic [31:0] a, input logic [31:0] d, input bit c);
    bit set;
    bit inw;
    int wi;
    we = w; addr = a; wdata = d; clr = c;
    @(posedge clk);
    set = 0;
    if (!m_ready) begin
      set = w;
      m_init++;
      if (m_init == MW) m_ready = 1;
    end else begin
      inw = (a < 32'(4 * MW));
      wi  = int'(a >> 2) % MW;
      if (w) begin
        if (inw && (a % 4 == 0) && (be_drv != 4'h0)) begin
          for (int l = 0; l < 4; l++)
            if (be_drv[l]) m_mem[wi][8*l +: 8] = d[8*l +: 8];
          m_rd = m_mem[wi];
          m_wc++;
        end else begin
          set = 1;
        end
      end else if (inw) begin
        m_rd = m_mem[wi];
        m_rc++;
      end else begin
        m_rd = 32'hFFFF_FFFF;
      end
    end
    if (set) m_err = 1;
    else if (c) m_err = 0;
    #1;
    compare_all();
    $display("[%0t] we=%0b addr=%08h wd=%08h be=%h clr=%0b -> rd=%08h rdy=%0b err=%0b rc=%0d wc=%0d",
             $time, w, a, d, be_drv, c, rd_data, ready, err, rd_cnt, wr_cnt);
  endtask

  // Assert reset away from the edge, confirm it acts without a clock, hold a few cycles.
  task automatic apply_reset();
    we = 0; clr = 0;
    z_r = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (3) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    z_r = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5)      return {24'h0, 6'($urandom_range(0, MW - 1)), 2'b00};
    else if (r == 6) return 32'($urandom_range(0, 4 * MW - 1));
    else if (r == 7) return 32'(4 * MW - 8 + $urandom_range(0, 15));
    else if (r == 8) return $urandom();
    else             return 32'hFFFF_FFFC;
  endfunction

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
`ifdef MIPS_DMEM_BYTE_EN
      be_drv = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
`endif
      do_cycle($urandom_range(0, 9) < 4, rand_addr(), $urandom(), $urandom_range(0, 9) == 0);
    end
    be_drv = 4'hF;
  endtask

  initial begin
    @(posedge clk);
    #1;
    apply_reset();

    // Init sweep with a write (dropped, flags error) and a later clear.
    for (int i = 0; i < MW; i++)
      do_cycle(i == 10, rand_addr(), 32'hCAFE_0000 + 32'(i), i == 20);
    check("ready_after_sweep", 32'(ready), 32'd1);

    // Directed traffic.
    do_cycle(0, 32'h0FC, '0, 0);
    check("read_0fc_zero", rd_data, 32'h0);
    do_cycle(1, 32'h010, 32'hDEAD_BEEF, 0);
    check("write_first", rd_data, 32'hDEAD_BEEF);
    check("wr_cnt_one", 32'(wr_cnt), 32'd1);
    do_cycle(0, 32'h010, '0, 0);
    check("read_back", rd_data, 32'hDEAD_BEEF);
    do_cycle(0, 32'h100, '0, 0);
    check("read_out_of_window", rd_data, 32'hFFFF_FFFF);
    do_cycle(1, 32'h100, 32'h1234_5678, 0);
    check("err_oow_write", 32'(err), 32'd1);
    do_cycle(0, 32'h000, '0, 1);
    check("err_cleared", 32'(err), 32'd0);
    do_cycle(1, 32'h012, 32'h5555_AAAA, 0);
    do_cycle(1, 32'h100, 32'h0, 1);
    check("err_set_beats_clr", 32'(err), 32'd1);
    do_cycle(0, 32'h013, '0, 1);
    check("misaligned_write_dropped", rd_data, 32'hDEAD_BEEF);

    // Counter saturation.
    for (int i = 0; i < 20; i++) do_cycle(0, 32'(4 * (i % MW)), '0, 0);
    check("rd_cnt_saturated", 32'(rd_cnt), 32'hF);

`ifdef MIPS_DMEM_BYTE_EN
    be_drv = 4'hF;
    do_cycle(1, 32'h020, 32'h1122_3344, 0);
    be_drv = 4'b0101;
    do_cycle(1, 32'h020, 32'hAABB_CCDD, 0);
    check("byte_merge_wf", rd_data, 32'h11BB_33DD);
    be_drv = 4'h0;
    do_cycle(1, 32'h020, 32'hFFFF_FFFF, 0);
    check("be_zero_err", 32'(err), 32'd1);
    be_drv = 4'hF;
    do_cycle(0, 32'h020, '0, 1);
    check("byte_merge_read", rd_data, 32'h11BB_33DD);
`endif

    rand_cycles(300);

    // Reset mid-run, then again at sweep index 30; sweep must restart fully.
    apply_reset();
    for (int i = 0; i < 30; i++) do_cycle(0, rand_addr(), '0, 0);
    apply_reset();
    for (int i = 0; i < MW; i++)
      do_cycle(i == 5, rand_addr(), 32'hBAD0_0000, i == 12);
    do_cycle(0, 32'h010, '0, 0);
    check("zeroed_after_reset", rd_data, 32'h0);

    rand_cycles(150);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
